// File: rtl/ritc_pkg.sv
// Shared definitions for the RITC lane-alignment sequencer: FSM encoding,
// user-register addresses and the layout of the register-1 write word.
package ritc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_SETTLE,
      ST_READ,
      ST_CMP,
      ST_SLIP,
      ST_NEXT,
      ST_DONE
   } state_t;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_TRAIN = 2'd1;

   localparam int BITSLIP_POS = 7;
   localparam int TRAIN_POS   = 6;
   localparam int CH_MSB      = 5;
   localparam int CH_LSB      = 4;
   localparam int BIT_MSB     = 3;
   localparam int BIT_LSB     = 0;

   localparam int NUM_CH      = 3;
   localparam int BITS_PER_CH = 12;

   function automatic logic [5:0] lane_index(input logic [1:0] ch, input logic [3:0] bit_idx);
      return 6'(32'(ch) * BITS_PER_CH + 32'(bit_idx));
   endfunction

   function automatic logic [7:0] make_wdata(input logic slip, input logic train,
                                             input logic [1:0] ch, input logic [3:0] bit_idx);
      logic [7:0] w;
      w                  = '0;
      w[BITSLIP_POS]     = slip;
      w[TRAIN_POS]       = train;
      w[CH_MSB:CH_LSB]   = ch;
      w[BIT_MSB:BIT_LSB] = bit_idx;
      return w;
   endfunction

endpackage

// File: rtl/ritc_user_bus_master.sv
// Single-cycle initiator for the RITC user register port: strobes follow the
// request combinationally, addr/data hold their last value between transfers.
module ritc_user_bus_master
   import ritc_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_wr_req,
   input  logic       i_rd_req,
   input  logic [1:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic       user_sel_o,
   output logic [1:0] user_addr_o,
   output logic [7:0] user_dat_o,
   output logic       user_wr_o,
   output logic       user_rd_o,
   input  logic [7:0] user_dat_i,
   output logic [7:0] o_rdata,
   output logic       o_ack
);

   logic [1:0] r_addr;
   logic [7:0] r_wdata;
   logic [7:0] r_rdata;
   logic       r_ack;
   logic       w_req;

   assign w_req = i_wr_req | i_rd_req;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_addr  <= REG_CTRL;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= w_req;
         if (w_req)
            r_addr <= i_addr;
         if (i_wr_req)
            r_wdata <= i_wdata;
         if (i_rd_req)
            r_rdata <= user_dat_i;
      end
   end

   // Strobes derive from the FSM state, so an async reset drops them at once.
   assign user_sel_o  = w_req;
   assign user_wr_o   = i_wr_req;
   assign user_rd_o   = i_rd_req;
   assign user_addr_o = w_req ? i_addr : r_addr;
   assign user_dat_o  = i_wr_req ? i_wdata : r_wdata;
   assign o_rdata     = r_rdata;
   assign o_ack       = r_ack;

endmodule

// File: rtl/ritc_align_sequencer.sv
// Walks all 36 RITC lanes: select, settle, read train_sync, bitslip until the
// training pattern appears or the slip budget runs out.
module ritc_align_sequencer
   import ritc_pkg::*;
#(
   parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
   parameter int         SETTLE_CYCLES = 32,
   parameter int         MAX_SLIPS     = 8,
   parameter logic       TRAIN_BIT     = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start_i,
   output logic        user_sel_o,
   output logic [1:0]  user_addr_o,
   output logic [7:0]  user_dat_o,
   output logic        user_wr_o,
   output logic        user_rd_o,
   input  logic [7:0]  user_dat_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fail_o,
   output logic [35:0] fail_mask_o,
   output logic [3:0]  slips_o
);

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_ch;
   logic [3:0]  r_bit;
   logic [3:0]  r_slip_cnt;
   logic [7:0]  r_settle_cnt;
   logic [35:0] r_fail_mask;
   logic        r_fail;
   logic [3:0]  r_slips;

   logic        w_wr_req;
   logic        w_rd_req;
   logic        w_slip_bit;
   logic [7:0]  w_wdata;
   logic [7:0]  w_rdata;
   logic        w_ack;
   logic        w_last;
   logic        w_match;
   logic        w_lane_fail;
   logic [5:0]  w_lane;

   assign w_last      = (r_ch == 2'(NUM_CH - 1)) && (r_bit == 4'(BITS_PER_CH - 1));
   assign w_lane      = lane_index(r_ch, r_bit);
   assign w_match     = (w_rdata == TRAIN_PATTERN);
   assign w_lane_fail = (r_state == ST_CMP) && w_ack && !w_match && (r_slip_cnt == 4'(MAX_SLIPS));
   assign w_wdata     = make_wdata(w_slip_bit, TRAIN_BIT, r_ch, r_bit);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_wr_req   = 1'b0;
      w_rd_req   = 1'b0;
      w_slip_bit = 1'b0;
      case (r_state)
         ST_IDLE:   if (start_i) w_next = ST_SEL;
         ST_SEL: begin
            w_wr_req = 1'b1;
            w_next   = ST_SETTLE;
         end
         ST_SETTLE: if (r_settle_cnt == 8'(SETTLE_CYCLES - 1)) w_next = ST_READ;
         ST_READ: begin
            w_rd_req = 1'b1;
            w_next   = ST_CMP;
         end
         ST_CMP: begin
            if (w_ack) begin
               if (w_match || (r_slip_cnt == 4'(MAX_SLIPS)))
                  w_next = ST_NEXT;
               else
                  w_next = ST_SLIP;
            end
         end
         ST_SLIP: begin
            w_wr_req   = 1'b1;
            w_slip_bit = 1'b1;
            w_next     = ST_SETTLE;
         end
         ST_NEXT:   w_next = w_last ? ST_DONE : ST_SEL;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ch         <= '0;
         r_bit        <= '0;
         r_slip_cnt   <= '0;
         r_settle_cnt <= '0;
         r_fail_mask  <= '0;
         r_fail       <= 1'b0;
         r_slips      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_ch        <= '0;
                  r_bit       <= '0;
                  r_slip_cnt  <= '0;
                  r_fail_mask <= '0;
                  r_fail      <= 1'b0;
               end
            end
            ST_SEL:    r_settle_cnt <= '0;
            ST_SLIP: begin
               r_settle_cnt <= '0;
               r_slip_cnt   <= r_slip_cnt + 4'd1;
            end
            ST_SETTLE: r_settle_cnt <= r_settle_cnt + 8'd1;
            ST_CMP:    if (w_lane_fail) r_fail_mask[w_lane] <= 1'b1;
            ST_NEXT: begin
               r_slips    <= r_slip_cnt;
               r_slip_cnt <= '0;
               // Bit field wraps at 12 into the next channel; codes 12..15 never appear.
               if (!w_last) begin
                  if (r_bit == 4'(BITS_PER_CH - 1)) begin
                     r_bit <= '0;
                     r_ch  <= r_ch + 2'd1;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end
            end
            ST_DONE:   r_fail <= |r_fail_mask;
            default: ;
         endcase
      end
   end

   ritc_user_bus_master u_bus (
      .CLK         (CLK),
      .RST         (RST),
      .i_wr_req    (w_wr_req),
      .i_rd_req    (w_rd_req),
      .i_addr      (REG_TRAIN),
      .i_wdata     (w_wdata),
      .user_sel_o  (user_sel_o),
      .user_addr_o (user_addr_o),
      .user_dat_o  (user_dat_o),
      .user_wr_o   (user_wr_o),
      .user_rd_o   (user_rd_o),
      .user_dat_i  (user_dat_i),
      .o_rdata     (w_rdata),
      .o_ack       (w_ack)
   );

   assign busy_o      = (r_state != ST_IDLE);
   assign done_o      = (r_state == ST_DONE);
   assign fail_o      = r_fail;
   assign fail_mask_o = r_fail_mask;
   assign slips_o     = r_slips;

endmodule

// File: tb/tb_ritc_align_sequencer.sv
// Directed bench for ritc_align_sequencer with a behavioural RITC register-1
// responder; one DUT with TRAIN_BIT=0 and one with TRAIN_BIT=1.
module tb_ritc_align_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   always #5 CLK = ~CLK;

   // ---------------- DUT (TRAIN_BIT=0) ----------------
   logic        start_i = 1'b0;
   logic        user_sel_o, user_wr_o, user_rd_o;
   logic [1:0]  user_addr_o;
   logic [7:0]  user_dat_o, user_dat_i;
   logic        busy_o, done_o, fail_o;
   logic [35:0] fail_mask_o;
   logic [3:0]  slips_o;

   ritc_align_sequencer #(.TRAIN_PATTERN(8'hF0), .SETTLE_CYCLES(4), .MAX_SLIPS(8), .TRAIN_BIT(1'b0)) dut (
      .CLK(CLK), .RST(RST), .start_i(start_i),
      .user_sel_o(user_sel_o), .user_addr_o(user_addr_o), .user_dat_o(user_dat_o),
      .user_wr_o(user_wr_o), .user_rd_o(user_rd_o), .user_dat_i(user_dat_i),
      .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
      .fail_mask_o(fail_mask_o), .slips_o(slips_o)
   );

   // ---------------- DUT (TRAIN_BIT=1) ----------------
   logic        t_start = 1'b0;
   logic        t_sel, t_wr, t_rd;
   logic [1:0]  t_addr;
   logic [7:0]  t_dat_o;
   logic [7:0]  t_dat_i = 8'hF0;
   logic        t_busy, t_done, t_fail;
   logic [35:0] t_mask;
   logic [3:0]  t_slips;

   ritc_align_sequencer #(.TRAIN_PATTERN(8'hF0), .SETTLE_CYCLES(4), .MAX_SLIPS(8), .TRAIN_BIT(1'b1)) dut_t (
      .CLK(CLK), .RST(RST), .start_i(t_start),
      .user_sel_o(t_sel), .user_addr_o(t_addr), .user_dat_o(t_dat_o),
      .user_wr_o(t_wr), .user_rd_o(t_rd), .user_dat_i(t_dat_i),
      .busy_o(t_busy), .done_o(t_done), .fail_o(t_fail),
      .fail_mask_o(t_mask), .slips_o(t_slips)
   );

   // ---------------- responder model ----------------
   // A targeted select reads back 0x0F until it has seen tgt_need slip writes.
   logic        tgt_en    = 1'b0;
   logic [5:0]  tgt_sel   = 6'd0;
   int          tgt_need  = 0;
   int          slip_base = 0;
   int          slip_tot[64];

   initial for (int i = 0; i < 64; i++) slip_tot[i] = 0;

   assign user_dat_i = (user_addr_o == 2'd1 && tgt_en && user_dat_o[5:0] == tgt_sel &&
                        (slip_tot[tgt_sel] - slip_base) < tgt_need) ? 8'h0F : 8'hF0;

   // ---------------- bus monitors ----------------
   logic [7:0] wr_q[$];
   logic [3:0] sl_q[$];
   logic [7:0] t_wr_q[$];
   logic [7:0] exp_q[$];
   int rd_cnt = 0, done_cnt = 0, proto_err = 0;
   int t_proto = 0, t_done_cnt = 0;

   always @(negedge CLK) begin
      if (user_sel_o) begin
         if ((user_wr_o == user_rd_o) || (user_addr_o != 2'd1)) proto_err++;
         if (user_wr_o) begin
            wr_q.push_back(user_dat_o);
            if (user_dat_o[7]) slip_tot[user_dat_o[5:0]]++;
            else sl_q.push_back(slips_o);
         end
         if (user_rd_o) rd_cnt++;
      end else if (user_wr_o || user_rd_o) begin
         proto_err++;
      end
      if (done_o) done_cnt++;
   end

   always @(negedge CLK) begin
      if (t_sel) begin
         if ((t_wr == t_rd) || (t_addr != 2'd1)) t_proto++;
         if (t_wr) t_wr_q.push_back(t_dat_o);
      end else if (t_wr || t_rd) begin
         t_proto++;
      end
      if (t_done) t_done_cnt++;
   end

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;
   int wr_base, sl_base, rd_base, done_base, proto_base;
   int cycles;
   logic seq_done;

   task automatic build_exp(input int tgt, input int nslip);
      logic [7:0] s;
      exp_q.delete();
      for (int c = 0; c < 3; c++)
         for (int b = 0; b < 12; b++) begin
            s = 8'(c * 16 + b);
            exp_q.push_back(s);
            if (int'(s) == tgt)
               for (int k = 0; k < nslip; k++) exp_q.push_back(s | 8'h80);
         end
   endtask

   // Pulse start and count cycles, start cycle = 1, through the done cycle.
   task automatic run_seq(input int pulse_lane);
      bit pulsed;
      pulsed     = 1'b0;
      wr_base    = wr_q.size();
      sl_base    = sl_q.size();
      rd_base    = rd_cnt;
      done_base  = done_cnt;
      proto_base = proto_err;
      @(negedge CLK); start_i = 1'b1; cycles = 1;
      @(negedge CLK); start_i = 1'b0; cycles = 2;
      while (!done_o && cycles < 3000) begin
         @(negedge CLK);
         cycles++;
         start_i = 1'b0;
         if (pulse_lane >= 0 && !pulsed && (wr_q.size() - wr_base) == pulse_lane + 1) begin
            start_i = 1'b1;
            pulsed  = 1'b1;
         end
      end
      seq_done = done_o;
      start_i  = 1'b0;
      @(negedge CLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      n_cmp++; if ({user_sel_o, user_wr_o, user_rd_o, busy_o, done_o, fail_o} !== 6'b0) begin
         n_err++; $display("FAIL reset_strobes: got %b want 000000", {user_sel_o, user_wr_o, user_rd_o, busy_o, done_o, fail_o}); end
      n_cmp++; if ({user_addr_o, user_dat_o, slips_o} !== 14'h0) begin
         n_err++; $display("FAIL reset_addr_dat_slips: got %h want 0", {user_addr_o, user_dat_o, slips_o}); end
      n_cmp++; if (fail_mask_o !== 36'h0) begin
         n_err++; $display("FAIL reset_mask: got %h want 0", fail_mask_o); end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      n_cmp++; if ({busy_o, user_sel_o} !== 2'b00) begin
         n_err++; $display("FAIL reset_idle_after_release: got %b want 00", {busy_o, user_sel_o}); end
   endtask

   task automatic test_all_match();
      tgt_en = 1'b0;
      build_exp(-1, 0);
      run_seq(-1);
      n_cmp++; if (!seq_done) begin n_err++; $display("FAIL all_match_done: timed out after %0d cycles", cycles); end
      n_cmp++; if (cycles != 36 * 8 + 2) begin n_err++; $display("FAIL all_match_cycles: got %0d want %0d", cycles, 36 * 8 + 2); end
      n_cmp++; if (wr_q.size() - wr_base != 36) begin n_err++; $display("FAIL all_match_nwrites: got %0d want 36", wr_q.size() - wr_base); end
      for (int i = 0; i < exp_q.size() && wr_base + i < wr_q.size(); i++) begin
         n_cmp++; if (wr_q[wr_base + i] !== exp_q[i]) begin
            n_err++; $display("FAIL all_match_write[%0d]: got %h want %h", i, wr_q[wr_base + i], exp_q[i]); end
      end
      n_cmp++; if (rd_cnt - rd_base != 36) begin n_err++; $display("FAIL all_match_nreads: got %0d want 36", rd_cnt - rd_base); end
      n_cmp++; if (done_cnt - done_base != 1) begin n_err++; $display("FAIL all_match_done_pulses: got %0d want 1", done_cnt - done_base); end
      n_cmp++; if ({fail_o, fail_mask_o} !== 37'h0) begin n_err++; $display("FAIL all_match_fail: got %b/%h want 0/0", fail_o, fail_mask_o); end
      n_cmp++; if (proto_err != proto_base) begin n_err++; $display("FAIL all_match_protocol: got %0d violations want 0", proto_err - proto_base); end
   endtask

   task automatic test_slip_lane13();
      int n91;
      tgt_en = 1'b1; tgt_sel = 6'h11; tgt_need = 3; slip_base = slip_tot[6'h11];
      build_exp(8'h11, 3);
      run_seq(-1);
      n91 = 0;
      for (int i = wr_base; i < wr_q.size(); i++) if (wr_q[i] == 8'h91) n91++;
      n_cmp++; if (!seq_done) begin n_err++; $display("FAIL slip13_done: timed out after %0d cycles", cycles); end
      n_cmp++; if (n91 != 3) begin n_err++; $display("FAIL slip13_n91: got %0d want 3", n91); end
      n_cmp++; if (cycles != 36 * 8 + 2 + 3 * 7) begin n_err++; $display("FAIL slip13_cycles: got %0d want %0d", cycles, 36 * 8 + 2 + 21); end
      for (int i = 0; i < exp_q.size() && wr_base + i < wr_q.size(); i++) begin
         n_cmp++; if (wr_q[wr_base + i] !== exp_q[i]) begin
            n_err++; $display("FAIL slip13_write[%0d]: got %h want %h", i, wr_q[wr_base + i], exp_q[i]); end
      end
      n_cmp++; if (sl_q.size() - sl_base != 36) begin n_err++; $display("FAIL slip13_nsel: got %0d want 36", sl_q.size() - sl_base); end
      else begin
         n_cmp++; if (sl_q[sl_base + 14] !== 4'd3) begin n_err++; $display("FAIL slip13_slips_after_13: got %0d want 3", sl_q[sl_base + 14]); end
         n_cmp++; if (sl_q[sl_base + 15] !== 4'd0) begin n_err++; $display("FAIL slip13_slips_after_14: got %0d want 0", sl_q[sl_base + 15]); end
      end
      n_cmp++; if ({fail_o, fail_mask_o} !== 37'h0) begin n_err++; $display("FAIL slip13_fail: got %b/%h want 0/0", fail_o, fail_mask_o); end
      tgt_en = 1'b0;
   endtask

   task automatic test_fail_lane35();
      int nab;
      tgt_en = 1'b1; tgt_sel = 6'h2B; tgt_need = 1000; slip_base = slip_tot[6'h2B];
      build_exp(8'h2B, 8);
      run_seq(-1);
      nab = 0;
      for (int i = wr_base; i < wr_q.size(); i++) if (wr_q[i] == 8'hAB) nab++;
      n_cmp++; if (!seq_done) begin n_err++; $display("FAIL fail35_done: timed out after %0d cycles", cycles); end
      n_cmp++; if (nab != 8) begin n_err++; $display("FAIL fail35_nAB: got %0d want 8", nab); end
      n_cmp++; if (cycles != 36 * 8 + 2 + 8 * 7) begin n_err++; $display("FAIL fail35_cycles: got %0d want %0d", cycles, 36 * 8 + 2 + 56); end
      n_cmp++; if (wr_q.size() - wr_base != exp_q.size()) begin
         n_err++; $display("FAIL fail35_nwrites: got %0d want %0d", wr_q.size() - wr_base, exp_q.size()); end
      n_cmp++; if (fail_mask_o !== 36'h8_0000_0000) begin n_err++; $display("FAIL fail35_mask: got %h want 800000000", fail_mask_o); end
      n_cmp++; if (fail_o !== 1'b1) begin n_err++; $display("FAIL fail35_fail_o: got %b want 1", fail_o); end
      n_cmp++; if (slips_o !== 4'd8) begin n_err++; $display("FAIL fail35_slips: got %0d want 8", slips_o); end
      tgt_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int wait_cyc;
      wr_base = wr_q.size();
      @(negedge CLK); start_i = 1'b1;
      @(negedge CLK); start_i = 1'b0;
      wait_cyc = 0;
      while ((wr_q.size() - wr_base) < 6 && wait_cyc < 500) begin @(negedge CLK); wait_cyc++; end
      n_cmp++; if ((wr_q.size() - wr_base) != 6) begin n_err++; $display("FAIL rstmid_reach_lane5: got %0d writes want 6", wr_q.size() - wr_base); end
      repeat (2) @(negedge CLK);
      n_cmp++; if ({busy_o, fail_o, fail_mask_o} !== {1'b1, 1'b0, 36'h0}) begin
         n_err++; $display("FAIL rstmid_cleared_on_start: got busy=%b fail=%b mask=%h want 1/0/0", busy_o, fail_o, fail_mask_o); end
      RST = 1'b1;
      #1;
      n_cmp++; if ({user_sel_o, user_wr_o, user_rd_o, busy_o} !== 4'b0) begin
         n_err++; $display("FAIL rstmid_outputs: got %b want 0000", {user_sel_o, user_wr_o, user_rd_o, busy_o}); end
      @(negedge CLK); RST = 1'b0;
      build_exp(-1, 0);
      run_seq(-1);
      n_cmp++; if (wr_q.size() <= wr_base || wr_q[wr_base] !== 8'h00) begin
         n_err++; $display("FAIL rstmid_restart_lane0: first write wrong or missing (n=%0d)", wr_q.size() - wr_base); end
      n_cmp++; if (cycles != 36 * 8 + 2) begin n_err++; $display("FAIL rstmid_cycles: got %0d want %0d", cycles, 36 * 8 + 2); end
      n_cmp++; if ({fail_o, fail_mask_o} !== 37'h0) begin n_err++; $display("FAIL rstmid_fail: got %b/%h want 0/0", fail_o, fail_mask_o); end
   endtask

   task automatic test_start_while_busy();
      tgt_en = 1'b0;
      run_seq(10);
      repeat (20) @(negedge CLK);
      n_cmp++; if (!seq_done) begin n_err++; $display("FAIL busy_start_done: timed out after %0d cycles", cycles); end
      n_cmp++; if (cycles != 36 * 8 + 2) begin n_err++; $display("FAIL busy_start_cycles: got %0d want %0d", cycles, 36 * 8 + 2); end
      n_cmp++; if (done_cnt - done_base != 1) begin n_err++; $display("FAIL busy_start_done_pulses: got %0d want 1", done_cnt - done_base); end
      n_cmp++; if (wr_q.size() - wr_base != 36) begin n_err++; $display("FAIL busy_start_nwrites: got %0d want 36", wr_q.size() - wr_base); end
      else begin
         n_cmp++; if (wr_q[wr_base + 11] !== 8'h0B) begin n_err++; $display("FAIL busy_start_lane11: got %h want 0b", wr_q[wr_base + 11]); end
      end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL busy_start_idle: got %b want 0", busy_o); end
   endtask

   task automatic test_train_bit();
      int base, no_b6, wait_cyc;
      base = t_wr_q.size();
      @(negedge CLK); t_start = 1'b1;
      @(negedge CLK); t_start = 1'b0;
      wait_cyc = 0;
      while (!t_done && wait_cyc < 3000) begin @(negedge CLK); wait_cyc++; end
      n_cmp++; if (!t_done) begin n_err++; $display("FAIL train_done: timed out after %0d cycles", wait_cyc); end
      repeat (2) @(negedge CLK);
      no_b6 = 0;
      for (int i = base; i < t_wr_q.size(); i++) if (!t_wr_q[i][6]) no_b6++;
      n_cmp++; if (t_wr_q.size() - base != 36) begin n_err++; $display("FAIL train_nwrites: got %0d want 36", t_wr_q.size() - base); end
      else begin
         n_cmp++; if (t_wr_q[base + 27] !== 8'h63) begin n_err++; $display("FAIL train_ch2_bit3: got %h want 63", t_wr_q[base + 27]); end
         n_cmp++; if (t_wr_q[base] !== 8'h40) begin n_err++; $display("FAIL train_lane0: got %h want 40", t_wr_q[base]); end
      end
      n_cmp++; if (no_b6 != 0) begin n_err++; $display("FAIL train_bit6: %0d writes without bit 6 want 0", no_b6); end
      n_cmp++; if (t_proto != 0) begin n_err++; $display("FAIL train_protocol: got %0d violations want 0", t_proto); end
      n_cmp++; if ({t_fail, t_mask, t_done_cnt == 1} !== {1'b0, 36'h0, 1'b1}) begin
         n_err++; $display("FAIL train_status: got fail=%b mask=%h dones=%0d want 0/0/1", t_fail, t_mask, t_done_cnt); end
   endtask

   initial begin
      test_reset();
      test_all_match();
      test_slip_lane13();
      test_fail_lane35();
      test_reset_mid();
      test_start_while_busy();
      test_train_bit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ritc_align_sequencer.md
Name: ritc_align_sequencer

Overview:
- Bus initiator that drives the 8-bit RITC controller user register interface to align all 36 deserialized lanes automatically: 3 channels x 12 bits.
- For each lane it performs these steps in order:
  - writes the training select to register 1;
  - waits for the train_sync pipeline to settle;
  - reads register 1 and compares the result against the expected training pattern;
  - issues bitslip writes until the lane matches or the retry limit is reached.
- Sits between the board control logic (start/status) and the controller's user_* port, replacing manual software alignment.

Parameters:
- TRAIN_PATTERN, 8'hF0, expected register-1 readback (train_sync) for an aligned lane.
- SETTLE_CYCLES, 32, CLK cycles waited after any register-1 write before reading. Range 1..255.
- MAX_SLIPS, 8, bitslips allowed per lane before the lane is declared failed. Range 1..15.
- TRAIN_BIT, 1'b0, value driven on data bit 6 (TRAINING control) in every register-1 write.

Ports:
- CLK  in  1  system clock, same domain as the controller.
- RST  in  1  asynchronous active-high reset.
- start_i  in  1  single-cycle request; ignored unless idle.
- user_sel_o  out  1  bus select.
- user_addr_o  out  2  register address; always 2'd1 during a sequence.
- user_dat_o  out  8  write data {bitslip, TRAIN_BIT, ch[1:0], bit[3:0]}.
- user_wr_o  out  1  write strobe.
- user_rd_o  out  1  read strobe.
- user_dat_i  in  8  read data from the controller; combinational on address.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle pulse at the end of a sequence.
- fail_o  out  1  high if any lane failed; held until the next start.
- fail_mask_o  out  36  bit n is set if lane n failed; held until the next start.
- slips_o  out  4  slip count of the most recently completed lane.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, lane 0, slip counter 0.
- Lane index: n = ch*12 + bit, with ch = 0..2 and bit = 0..11. Select encoding is {ch[1:0], bit[3:0]}; bit codes 12..15 are never issued.
- Bus transaction: exactly one cycle with user_sel_o=1 plus exactly one of user_wr_o/user_rd_o. Addr and data are stable during that cycle. At all other times sel, wr and rd are 0; addr and data hold their last value.
- Read: user_dat_i is registered on the rising edge that ends the read cycle. The compare uses the registered value in the following cycle.
- States:
  - IDLE: on start_i, clear fail_mask_o and fail_o, set lane=0 and slip counter=0, go to SEL.
  - SEL: write cycle with bitslip=0, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles (counter reset on entry), then go to READ.
  - READ: read cycle, go to CMP.
  - CMP:
    - If the data equals TRAIN_PATTERN, go to NEXT.
    - Else if the slip counter equals MAX_SLIPS, set fail_mask_o[n] and go to NEXT.
    - Else go to SLIP.
  - SLIP: write cycle with bitslip=1 and the same select. Slip counter +1. Go to SETTLE. SEL is not re-entered, so no redundant select write is issued.
  - NEXT: slips_o <= slip counter; slip counter <= 0.
    - If lane=35, go to DONE.
    - Else lane+1 and go to SEL. The bit field wraps from 11 to 0 with ch+1.
  - DONE: done_o=1 for one cycle; fail_o <= OR of fail_mask_o; go to IDLE.
- start_i while not IDLE is ignored. It does not restart the sequence.
- RST mid-sequence: return to IDLE immediately. Any bus strobe in progress is deasserted asynchronously and no partial transaction completes.
- Slip counter width is 4 bits; with MAX_SLIPS at most 15 it cannot overflow.
- Minimum lane time: 1+SETTLE_CYCLES+1+1+1 cycles. Each slip adds 1+SETTLE_CYCLES+2 cycles.

Decomposition:
- Shared package (ritc_pkg): state encoding; register address constants REG_CTRL=0 and REG_TRAIN=1; write-data bit positions (BITSLIP=7, TRAIN=6, CH=5:4, BIT=3:0); NUM_CH=3, BITS_PER_CH=12.
- One natural sub-module: ritc_user_bus_master. It generates the single-cycle wr/rd strobes, registers read data, and pulses an ack the cycle after the strobe. The sequencer FSM issues requests to it.

Test Plan:
- All lanes match: responder returns 8'hF0 on every read with SETTLE_CYCLES=4.
  - 36 SEL writes with data 0x00..0x0B, 0x10..0x1B, 0x20..0x2B, and no bitslip writes.
  - done_o pulses once; fail_o=0, fail_mask_o=0.
  - Total cycles = 36*8 + 2.
- Lane 13 (ch1, bit1) needs 3 slips: the model returns 0x0F until the third write with data 0x91.
  - Exactly 3 writes of 0x91 are issued.
  - slips_o=3 after lane 13 completes; no failures.
- Lane 35 never matches with MAX_SLIPS=8.
  - 8 writes of 0xAB are issued.
  - fail_mask_o = 36'h8_0000_0000 and fail_o=1 at done.
- RST asserted during the SETTLE of lane 5.
  - sel, wr and rd go to 0 immediately; busy_o=0.
  - A subsequent start_i restarts at lane 0 with fail_mask cleared.
- start_i pulsed while busy (lane 10): no restart, the lane sequence continues, and done_o pulses exactly once.
- TRAIN_BIT=1: every write has bit 6 set (the SEL for ch2, bit3 writes 0x63); read strobes are never simultaneous with write strobes.
